wide_add_seq: RTL and testbench
===============================

// Module: wide_add_seq
// PURPOSE
//   Sequencer upstream of the registered 32-bit adder cla_clk. It runs one wide add, NWORDS*32 bits,
//   as NWORDS chained 32-bit passes through that adder.
//   - Drives the adder's a/b/ci ports one word at a time, LSW first.
//   - Collects each word's sum and feeds that word's carry-out into the next word's ci.
//   - Presents the wide result to its consumer on a valid/ready handshake.
// PARAMETERS
//   NWORDS     4   number of 32-bit words per operand (default 128-bit add); >= 1
//   ADDER_LAT  2   clock edges from adder input sampling to s/co visible (cla_clk = 2); >= 1
// PORTS
//   clk        in   1            rising-edge clock
//   reset_n    in   1            synchronous, active-low reset
//   in_valid   in   1            operand request
//   in_ready   out  1            block can accept an operand
//   op_a       in   32*NWORDS    operand A
//   op_b       in   32*NWORDS    operand B
//   op_ci      in   1            carry-in to word 0
//   out_valid  out  1            sum/cout valid
//   out_ready  in   1            consumer accepts result
//   sum        out  32*NWORDS    wide sum
//   cout       out  1            carry-out of the top word
//   add_a      out  32           to adder a
//   add_b      out  32           to adder b
//   add_ci     out  1            to adder ci
//   add_s      in   32           from adder s
//   add_co     in   1            from adder co
// BEHAVIOUR
//   - Single clock clk. reset_n is synchronous and active-low; it is sampled only on the rising edge of clk.
//   - Reset values:
//       - state = IDLE; idx = 0; wait count = 0.
//       - in_ready = 1 (combinational from state); out_valid = 0.
//       - sum = 0, cout = 0.
//       - add_a = 0, add_b = 0, add_ci = 0.
//   - FSM states:
//       - IDLE: in_ready = 1. On in_valid, capture op_a, op_b and carry = op_ci; set idx = 0; go to ISSUE.
//       - ISSUE: add_a/add_b = word idx of the captured operands, add_ci = carry. All are registered and held
//         stable through WAIT. Next state is WAIT with cnt = 0.
//       - WAIT: cnt increments each cycle. When cnt == ADDER_LAT-1:
//           - sum[32*idx +: 32] <= add_s; carry <= add_co.
//           - If idx == NWORDS-1: cout <= add_co and go to DONE.
//           - Otherwise: idx++ and go back to ISSUE.
//       - DONE: out_valid = 1; sum and cout are held stable. On out_ready, go to IDLE.
//   - Latency and throughput:
//       - Each word takes 1+ADDER_LAT cycles.
//       - out_valid rises NWORDS*(ADDER_LAT+1) edges after the accepting edge (12 at the defaults).
//   - Handshake rules:
//       - One operation in flight at a time. in_ready = 0 in ISSUE, WAIT and DONE; in_valid is ignored there.
//       - in_ready and out_valid are never high in the same cycle.
//       - If out_ready is already high on entry to DONE, DONE lasts one cycle and IDLE follows.
//       - sum/cout keep their last value after the handshake and are overwritten only word by word during the next operation.
//   - Width rules:
//       - Word k covers bits [32k+31:32k].
//       - The carry chain is exact across all words; no overflow flag beyond cout.
//   - Reset mid-operation:
//       - The operation is aborted and the block returns to IDLE with all outputs at reset values.
//       - Data still in the adder pipeline is never captured. A new op always waits the full ADDER_LAT per word.
// CONFIGURATION
//   WIDE_ADD_SUB_EN defined:
//       - Adds input port op_sub (1 bit), sampled together with the operands.
//       - When op_sub = 1: add_b = ~word of B, word-0 carry = 1 (op_ci ignored).
//         sum = A - B mod 2^(32*NWORDS); cout = 1 means no borrow.
//       - When op_sub = 0: plain add.
//   WIDE_ADD_SUB_EN undefined:
//       - No op_sub port; add only.
// TESTING (NWORDS=4, ADDER_LAT=2, DUT wired to cla_clk)
//   1. reset_n=0 for 2 edges mid-idle -> in_ready=1, out_valid=0, sum=0, cout=0, add_a/add_b/add_ci=0.
//   2. a=all ones, b=1, ci=0 -> sum=0, cout=1; out_valid exactly 12 edges after accept.
//   3. a=128'hFFFFFFFF, b=1, ci=1 -> sum=128'h1_00000001, cout=0 (carry into word 1 only).
//   4. Hold out_ready=0 for 5 cycles in DONE, pulse in_valid -> sum/cout stable, in_ready=0, request ignored; accepted after handshake.
//   5. reset_n=0 during WAIT of word 2 -> IDLE next edge, out_valid never rises. Then a=5, b=7, ci=0 -> sum=12, cout=0.
//   6. WIDE_ADD_SUB_EN: (a=0,b=1,sub=1) -> sum=all ones, cout=0; (a=5,b=3,sub=1) -> sum=2, cout=1.

Source files
------------

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - sequencer running one NWORDS*32-bit add as chained passes through a registered 32-bit adder
//
// Optional feature macro: WIDE_ADD_SUB_EN (adds op_sub; subtract A - B when set).
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   in_valid   in   operand request
//   in_ready   out  block can accept an operand (high only in IDLE)
//   op_a/op_b  in   wide operands, word k = bits [32k+31:32k]
//   op_ci      in   carry-in to word 0
//   op_sub     in   (WIDE_ADD_SUB_EN only) 1 = subtract
//   out_valid  out  sum/cout valid (high only in DONE)
//   out_ready  in   consumer accepts result
//   sum/cout   out  wide sum and carry-out of the top word
//   add_a/add_b/add_ci  out  word operands and carry driven to the adder
//   add_s/add_co        in   adder result, ADDER_LAT edges after sampling

module wide_add_seq #(
    parameter int NWORDS    = 4,
    parameter int ADDER_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*NWORDS-1:0]  op_a,
    input  logic [32*NWORDS-1:0]  op_b,
    input  logic                  op_ci,
`ifdef WIDE_ADD_SUB_EN
    input  logic                  op_sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*NWORDS-1:0]  sum,
    output logic                  cout,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic                  add_ci,
    input  logic [31:0]           add_s,
    input  logic                  add_co
);

    localparam int W     = 32 * NWORDS;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int CNT_W = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDER_LAT - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;

    // Effective B and word-0 carry; subtraction is A + ~B + 1.
    logic [W-1:0] b_eff;
    logic         ci_eff;
`ifdef WIDE_ADD_SUB_EN
    assign b_eff  = op_sub ? ~op_b : op_b;
    assign ci_eff = op_sub ? 1'b1 : op_ci;
`else
    assign b_eff  = op_b;
    assign ci_eff = op_ci;
`endif

    // Next word of the captured operands. Shifting rather than part-selecting
    // keeps the expression in range even when idx is the last word (value unused then).
    logic [IDX_W-1:0] next_idx;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    assign next_idx = idx + 1'b1;
    assign a_sh     = a_q >> {next_idx, 5'b0};
    assign b_sh     = b_q >> {next_idx, 5'b0};

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // The adder inputs are loaded on the edge that enters ISSUE, so the adder
    // samples them on the ISSUE->WAIT edge and the result is visible at the
    // WAIT edge where cnt reaches ADDER_LAT-1. add_ci doubles as the running carry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            add_a  <= '0;
            add_b  <= '0;
            add_ci <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q    <= op_a;
                        b_q    <= b_eff;
                        add_a  <= op_a[31:0];
                        add_b  <= b_eff[31:0];
                        add_ci <= ci_eff;
                        idx    <= '0;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        sum[{idx, 5'b0} +: 32] <= add_s;
                        add_ci                 <= add_co;
                        if (idx == IDX_LAST) begin
                            cout  <= add_co;
                            state <= S_DONE;
                        end else begin
                            idx   <= next_idx;
                            add_a <= a_sh[31:0];
                            add_b <= b_sh[31:0];
                            state <= S_ISSUE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - directed self-checking bench for wide_add_seq with a 2-stage registered adder model

module tb_wide_add_seq;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] op_a;
    logic [127:0] op_b;
    logic         op_ci;
`ifdef WIDE_ADD_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] sum;
    logic         cout;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_ci;
    logic [31:0]  add_s;
    logic         add_co;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wide_add_seq #(.NWORDS(4), .ADDER_LAT(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ci     (op_ci),
`ifdef WIDE_ADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .add_co    (add_co)
    );

    // Registered adder: inputs sampled on one edge, result visible after the next.
    logic [32:0] p1;
    logic [32:0] p2;
    always @(posedge clk) begin
        p1 <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};
        p2 <= p1;
    end
    assign add_s  = p2[31:0];
    assign add_co = p2[32];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand, return edges from accept to out_valid (0 on timeout).
    task automatic start_op(input logic [127:0] a, input logic [127:0] b, input logic ci,
                            input logic sub, output int lat);
        op_a     = a;
        op_b     = b;
        op_ci    = ci;
`ifdef WIDE_ADD_SUB_EN
        op_sub   = sub;
`else
        if (sub) $display("note: subtract requested without WIDE_ADD_SUB_EN");
`endif
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (out_valid) break;
            step();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                         input logic ci, input logic sub,
                         input logic [127:0] exp_sum, input logic exp_cout);
        int lat;
        start_op(a, b, ci, sub, lat);
        check({tag, " latency"}, 128'(lat), 128'd12);
        check({tag, " sum"}, sum, exp_sum);
        check({tag, " cout"}, 128'(cout), 128'(exp_cout));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " idle after ack"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        int lat;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_ci     = 1'b0;
`ifdef WIDE_ADD_SUB_EN
        op_sub    = 1'b0;
`endif
        step();
        step();
        check("rst in_ready", 128'(in_ready), 128'd1);
        check("rst out_valid", 128'(out_valid), 128'd0);
        check("rst sum", sum, 128'd0);
        check("rst cout", 128'(cout), 128'd0);
        check("rst add_abci", {63'd0, add_ci, add_a, add_b}, 128'd0);
        reset_n = 1'b1;
        step();

        do_op("allones+1", {128{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1);
        do_op("word0 carry", 128'hFFFFFFFF, 128'd1, 1'b1, 1'b0, 128'h1_00000001, 1'b0);
        do_op("mixed", 128'h01234567_89ABCDEF_FEDCBA98_76543210,
              128'h11111111_11111111_11111111_11111111, 1'b0, 1'b0,
              128'h12345678_9ABCDF01_0FEDCBA9_87654321, 1'b0);
        do_op("msb overflow", {1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0, 1'b0, 128'd0, 1'b1);

        // Result held in DONE while consumer stalls; new requests ignored.
        start_op(128'd1, 128'd2, 1'b0, 1'b0, lat);
        check("stall latency", 128'(lat), 128'd12);
        for (int i = 0; i < 5; i++) begin
            op_a     = 128'hDEAD;
            op_b     = 128'hBEEF;
            in_valid = (i == 2);
            step();
            check("stall sum", sum, 128'd3);
            check("stall flags", {125'd0, cout, in_ready, out_valid}, 128'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post-ack idle", 128'(in_ready), 128'd1);
        check("post-ack sum kept", sum, 128'd3);
        do_op("after stall", 128'd10, 128'd20, 1'b1, 1'b0, 128'd31, 1'b0);

        // out_ready already high on entry to DONE: one DONE cycle.
        out_ready = 1'b1;
        start_op(128'd100, 128'd200, 1'b0, 1'b0, lat);
        check("early ready latency", 128'(lat), 128'd12);
        check("early ready sum", sum, 128'd300);
        step();
        check("early ready one cycle", {126'd0, out_valid, in_ready}, 128'd1);
        out_ready = 1'b0;

        // Reset during WAIT of word 2 (7 edges after accept).
        op_a     = {4{32'hFFFFFFFF}};
        op_b     = {4{32'h12345678}};
        op_ci    = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("abort in_ready", 128'(in_ready), 128'd1);
        check("abort out_valid", 128'(out_valid), 128'd0);
        check("abort sum", sum, 128'd0);
        check("abort add_abci", {63'd0, add_ci, add_a, add_b}, 128'd0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 15; i++) begin
                step();
                if (out_valid) seen = 1'b1;
            end
            check("abort no out_valid", 128'(seen), 128'd0);
        end
        do_op("after abort", 128'd5, 128'd7, 1'b0, 1'b0, 128'd12, 1'b0);

`ifdef WIDE_ADD_SUB_EN
        do_op("sub 0-1", 128'd0, 128'd1, 1'b1, 1'b1, {128{1'b1}}, 1'b0);
        do_op("sub 5-3", 128'd5, 128'd3, 1'b0, 1'b1, 128'd2, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
